// File: rtl/prefix_subtractor_pkg.sv
// Shared prefix-network types for the adder/subtractor family.
// Generate/propagate pair and the associative prefix operator.
package prefix_pkg;

    localparam int PREFIX_W    = 8;
    localparam int PREFIX_LVLS = 3;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic pg_t pg_combine(pg_t hi, pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

endpackage

// File: rtl/prefix_subtractor_if.sv
// Valid/ready operand and result bus of prefix_subtractor.
// The ovf signal exists only when PREFIX_SUB_OVF_EN is defined.
interface prefix_subtractor_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef PREFIX_SUB_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef PREFIX_SUB_OVF_EN
        , output ovf
`endif
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef PREFIX_SUB_OVF_EN
        , input ovf
`endif
    );

endinterface

// File: rtl/prefix_subtractor_borrow_net.sv
// Combinational three-level Sklansky carry network over OR-propagate p/g terms.
// c_o[i] is the carry into bit i (c_o[0] = cin_i); cout_o is the carry out of the MSB.
module prefix_borrow_net
    import prefix_pkg::*;
#(
    parameter int WIDTH = PREFIX_W
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] g_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] c_o,
    output logic             cout_o
);

    // lv[l][i] holds the group term covering bit i down to the start of its 2^l block.
    pg_t lv [0:PREFIX_LVLS][0:WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign lv[0][i] = '{p: p_i[i], g: g_i[i]};
    end

    for (genvar l = 0; l < PREFIX_LVLS; l++) begin : g_lvl
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> l) & 1) == 1) begin : g_merge
                assign lv[l+1][i] = pg_combine(lv[l][i], lv[l][((i >> l) << l) - 1]);
            end else begin : g_pass
                assign lv[l+1][i] = lv[l][i];
            end
        end
    end

    assign c_o[0] = cin_i;

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_carry
        assign c_o[i+1] = lv[PREFIX_LVLS][i].g | (lv[PREFIX_LVLS][i].p & cin_i);
    end

    assign cout_o = lv[PREFIX_LVLS][WIDTH-1].g | (lv[PREFIX_LVLS][WIDTH-1].p & cin_i);

endmodule

// File: rtl/prefix_subtractor.sv
// Two-stage pipelined a - b - bin with borrow-out and bubble-free valid/ready flow.
// Optional signed-overflow output enabled by PREFIX_SUB_OVF_EN.
module prefix_subtractor
    import prefix_pkg::*;
#(
    parameter int WIDTH = PREFIX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    prefix_subtractor_if.slave bus
);

    logic             adv1, adv2, ld1, ld2;

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_nb_q, s1_nb_d;
    logic             s1_nbin_q, s1_nbin_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef PREFIX_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0] carry;
    logic             carry_out;
    logic [WIDTH-1:0] sum;

    prefix_borrow_net #(.WIDTH(WIDTH)) u_net (
        .p_i    (s1_p_q),
        .g_i    (s1_g_q),
        .cin_i  (s1_nbin_q),
        .c_o    (carry),
        .cout_o (carry_out)
    );

    assign sum = s1_a_q ^ s1_nb_q ^ carry;

    // Ready depends only on downstream ready and occupancy, never on in_valid.
    always_comb begin
        adv2      = !s2_v_q || bus.out_ready;
        adv1      = !s1_v_q || adv2;
        ld1       = adv1 && bus.in_valid;
        ld2       = adv2 && s1_v_q;

        s1_v_d    = adv1 ? bus.in_valid : s1_v_q;
        s1_a_d    = ld1 ? bus.a : s1_a_q;
        s1_nb_d   = ld1 ? ~bus.b : s1_nb_q;
        s1_nbin_d = ld1 ? ~bus.bin : s1_nbin_q;
        s1_p_d    = ld1 ? (bus.a | ~bus.b) : s1_p_q;
        s1_g_d    = ld1 ? (bus.a & ~bus.b) : s1_g_q;

        s2_v_d    = adv2 ? s1_v_q : s2_v_q;
        diff_d    = ld2 ? sum : diff_q;
        bout_d    = ld2 ? ~carry_out : bout_q;
`ifdef PREFIX_SUB_OVF_EN
        ovf_d     = ld2 ? ((s1_a_q[WIDTH-1] ^ ~s1_nb_q[WIDTH-1]) &
                           (s1_a_q[WIDTH-1] ^ sum[WIDTH-1])) : ovf_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_nb_q   <= '0;
            s1_nbin_q <= 1'b0;
            s1_p_q    <= '0;
            s1_g_q    <= '0;
            s2_v_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
`ifdef PREFIX_SUB_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_nb_q   <= s1_nb_d;
            s1_nbin_q <= s1_nbin_d;
            s1_p_q    <= s1_p_d;
            s1_g_q    <= s1_g_d;
            s2_v_q    <= s2_v_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
`ifdef PREFIX_SUB_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = s2_v_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef PREFIX_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
